hilo_mdu: RTL and testbench

Multiply/divide unit with architectural HI/LO registers for the E stage of the five-stage MIPS pipeline. It consumes the `HILO_type` code the decoder produces for the instruction in E, with rs/rt operands from the E-stage forwarding muxes. It runs mult/multu/div/divu as multi-cycle operations and executes mthi/mtlo/mfhi/mflo. It also drives the `start`/`busy` pair the hazard unit uses to stall md/mt/mf instructions in D.

---
 rtl/hilo_mdu.sv | 138 +++++++++++++
 tb/tb_hilo_mdu.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
// Multiply/divide unit with architectural HI/LO registers for the MIPS E stage.
// md operations run for a fixed latency and commit HI/LO when the countdown expires.
module hilo_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  HILO_type,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] out
);

  localparam logic [3:0] HILO_NONE  = 4'd0;
  localparam logic [3:0] HILO_MULT  = 4'd1;
  localparam logic [3:0] HILO_MULTU = 4'd2;
  localparam logic [3:0] HILO_DIV   = 4'd3;
  localparam logic [3:0] HILO_DIVU  = 4'd4;
  localparam logic [3:0] HILO_MFHI  = 4'd5;
  localparam logic [3:0] HILO_MFLO  = 4'd6;
  localparam logic [3:0] HILO_MTHI  = 4'd7;
  localparam logic [3:0] HILO_MTLO  = 4'd8;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} md_op_t;

  state_t      state_q, state_d;
  md_op_t      op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;

  logic        is_md;
  logic        is_signed_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, den, q_mag, r_mag, quot, rem;

  assign is_md = (HILO_type == HILO_MULT) || (HILO_type == HILO_MULTU) ||
                 (HILO_type == HILO_DIV)  || (HILO_type == HILO_DIVU);
  assign start = is_md && !req;
  assign busy  = (state_q == BUSY);

  always_comb begin
    case (HILO_type)
      HILO_MFHI: out = hi_q;
      HILO_MFLO: out = lo_q;
      default:   out = 32'd0;
    endcase
  end

  // Results come from the latched operands so later E-stage traffic cannot disturb them.
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

  // Signed divide on magnitudes: 0x80000000 / -1 yields 0x80000000 rem 0 without overflow traps.
  assign is_signed_div = (op_q == OP_DIV);
  assign a_mag = (is_signed_div && a_q[31]) ? -a_q : a_q;
  assign b_mag = (is_signed_div && b_q[31]) ? -b_q : b_q;
  assign den   = (b_q == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / den;
  assign r_mag = a_mag % den;
  assign quot  = (is_signed_div && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
  assign rem   = (is_signed_div && a_q[31]) ? -r_mag : r_mag;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = BUSY;
          case (HILO_type)
            HILO_MULT:  op_d = OP_MULT;
            HILO_MULTU: op_d = OP_MULTU;
            HILO_DIV:   op_d = OP_DIV;
            default:    op_d = OP_DIVU;
          endcase
          cnt_d = (HILO_type == HILO_MULT || HILO_type == HILO_MULTU) ? MULT_CYCLES : DIV_CYCLES;
        end else if (!req) begin
          if (HILO_type == HILO_MTHI) hi_d = A;
          if (HILO_type == HILO_MTLO) lo_d = A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            default: begin
              // Divide by zero still burns the full latency but leaves HI/LO alone.
              if (b_q != 32'd0) begin
                hi_d = rem;
                lo_d = quot;
              end
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu: latency, results, mt/mf, req gating, reset.
module tb_hilo_mdu;

  localparam logic [3:0] T_NONE  = 4'd0;
  localparam logic [3:0] T_MULT  = 4'd1;
  localparam logic [3:0] T_MULTU = 4'd2;
  localparam logic [3:0] T_DIV   = 4'd3;
  localparam logic [3:0] T_DIVU  = 4'd4;
  localparam logic [3:0] T_MFHI  = 4'd5;
  localparam logic [3:0] T_MFLO  = 4'd6;
  localparam logic [3:0] T_MTHI  = 4'd7;
  localparam logic [3:0] T_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  HILO_type;
  logic [31:0] A, B;
  logic        req;
  logic        start, busy;
  logic [31:0] out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hilo_mdu dut (
    .clk(clk), .reset(reset), .HILO_type(HILO_type), .A(A), .B(B),
    .req(req), .start(start), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic check_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    HILO_type = T_MFHI; #1;
    total_cnt++;
    if (out !== exp_hi) $display("FAIL %s_hi: out=0x%08h expected 0x%08h", name, out, exp_hi);
    else pass_cnt++;
    HILO_type = T_MFLO; #1;
    total_cnt++;
    if (out !== exp_lo) $display("FAIL %s_lo: out=0x%08h expected 0x%08h", name, out, exp_lo);
    else pass_cnt++;
    HILO_type = T_NONE; #1;
  endtask

  // Issues one md in the current cycle and counts busy cycles until it falls (bounded).
  task automatic issue_md(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                          input int n, input string name);
    int cycles;
    HILO_type = t; A = a; B = b; req = 1'b0; #1;
    total_cnt++;
    if (start !== 1'b1) $display("FAIL %s_start: start=%b expected 1", name, start);
    else pass_cnt++;
    step();
    HILO_type = T_NONE; A = 32'd0; B = 32'd0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      step();
    end
    total_cnt++;
    if (cycles !== n) $display("FAIL %s_latency: busy cycles=%0d expected %0d", name, cycles, n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; HILO_type = T_NONE; A = 32'd0; B = 32'd0; req = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    HILO_type = T_MULT; req = 1'b1; #1;
    chk("reset_start_req", {31'd0, start}, 32'd0);
    req = 1'b0; HILO_type = T_NONE; #1;
    chk("reset_start_none", {31'd0, start}, 32'd0);
    chk("reset_out_none", out, 32'd0);
    check_hilo(32'd0, 32'd0, "reset_hilo");
  endtask

  task automatic test_mult();
    issue_md(T_MULT, 32'hFFFF_FFFE, 32'd3, 5, "mult");
    check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    issue_md(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu");
    check_hilo(32'hFFFF_FFFE, 32'h0000_0001, "multu");
  endtask

  task automatic test_div();
    issue_md(T_DIV, 32'hFFFF_FFF9, 32'd2, 10, "div_neg");
    check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    issue_md(T_DIVU, 32'd7, 32'd0, 10, "divu_zero");
    check_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_zero");
    issue_md(T_DIV, 32'd7, 32'hFFFF_FFFE, 10, "div_negb");
    check_hilo(32'h0000_0001, 32'hFFFF_FFFD, "div_negb");
    issue_md(T_DIVU, 32'hFFFF_FFF0, 32'd7, 10, "divu");
    check_hilo(32'h0000_0002, 32'h2492_4922, "divu");
    issue_md(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
    check_hilo(32'h0000_0000, 32'h8000_0000, "div_ovf");
  endtask

  task automatic test_mt();
    HILO_type = T_MTHI; A = 32'h1234_5678; req = 1'b0;
    step();
    HILO_type = T_MFLO; A = 32'd0; #1;
    chk("mthi_mflo", out, 32'h8000_0000);
    step();
    HILO_type = T_MFHI; #1;
    chk("mthi_mfhi", out, 32'h1234_5678);
    HILO_type = T_MTLO; A = 32'hDEAD_BEEF; req = 1'b1;
    step();
    req = 1'b0; HILO_type = T_MFLO; #1;
    chk("mtlo_req", out, 32'h8000_0000);
    HILO_type = T_MTLO; A = 32'hCAFE_0001;
    step();
    HILO_type = T_MFLO; #1;
    chk("mtlo", out, 32'hCAFE_0001);
    HILO_type = T_NONE; #1;
  endtask

  task automatic test_req();
    int cycles;
    HILO_type = T_DIV; A = 32'd100; B = 32'd7; req = 1'b1; #1;
    chk("req_start", {31'd0, start}, 32'd0);
    step();
    chk("req_busy", {31'd0, busy}, 32'd0);
    req = 1'b0; HILO_type = T_DIV; A = 32'd100; B = 32'd7; #1;
    chk("req2_start", {31'd0, start}, 32'd1);
    step();
    HILO_type = T_NONE; A = 32'd0; B = 32'd0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 20) begin
      cycles++;
      // req pulse plus a stray mt at T+3, a stray md at T+5: none may disturb the div
      if (cycles == 3) begin req = 1'b1; HILO_type = T_MTLO; A = 32'h0000_AAAA; end
      else if (cycles == 5) begin req = 1'b0; HILO_type = T_MULT; A = 32'd2; B = 32'd3; end
      else begin req = 1'b0; HILO_type = T_NONE; end
      step();
    end
    req = 1'b0; HILO_type = T_NONE;
    chk("req2_latency", cycles, 32'd10);
    check_hilo(32'd2, 32'd14, "req2");
  endtask

  task automatic test_back_to_back();
    issue_md(T_MULT, 32'd3, 32'd4, 5, "b2b_first");
    issue_md(T_MULTU, 32'd5, 32'd6, 5, "b2b_second");
    check_hilo(32'd0, 32'd30, "b2b");
  endtask

  task automatic test_reset_mid();
    HILO_type = T_DIV; A = 32'd9; B = 32'd2; req = 1'b0;
    step();
    HILO_type = T_NONE;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    check_hilo(32'd0, 32'd0, "rmid");
    for (int i = 0; i < 8; i++) step();
    chk("rmid_late_busy", {31'd0, busy}, 32'd0);
    check_hilo(32'd0, 32'd0, "rmid_late");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_req();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
